sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
- Streaming 3x3 window generator placed directly upstream of the combinational Sobel operator.
- Accepts a raster-order 8-bit grayscale pixel stream from the camera/grayscale path.
- Buffers the two previous image lines in two line buffers and a 3x3 register array.
- Presents the nine window pixels (pixel0..pixel8, row-major, pixel4 = centre) with a valid strobe, only for fully interior windows.

Parameters:
- IMG_WIDTH, 640, active pixels per line (>=3)
- IMG_HEIGHT, 480, active lines per frame (>=3)
- PIX_W, 8, pixel width in bits

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_pixel is valid this cycle; no backpressure
- in_sof  in  1  start of frame; qualified by in_valid, marks pixel (0,0)
- in_pixel  in  PIX_W  grayscale pixel
- win_valid  out  1  window outputs valid; one-cycle pulse per window
- win_last  out  1  with win_valid, marks the last window of the frame
- pixel0..pixel8  out  PIX_W each  window: 0/1/2 top row, 3/4/5 middle, 6/7/8 bottom; left to right

Behaviour:
- Reset: asynchronous on rst_n low; synchronous release. All outputs go to 0. Column counter x = 0, row counter y = 0. Line-buffer contents don't care.
- Accepted pixel: in_valid = 1 at a rising edge. With in_valid = 0 all state holds and win_valid = 0.
- Position: the accepted pixel's position (x, y) comes from the counters, except when in_sof = 1, where the position is forced to (0,0).
- Counter advance after acceptance:
  - x increments.
  - At x = IMG_WIDTH-1, x wraps to 0 and y increments.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0, so the next pixel is treated as a new frame even without in_sof.
- in_sof with in_valid = 0 is ignored.
- Line buffers: LB0 holds row y-1 and LB1 holds row y-2, indexed by x. On acceptance at column x: LB1[x] <= LB0[x], LB0[x] <= in_pixel (read-before-write).
- Window register: on every accepted pixel the columns shift left. The new right column is {LB1[x], LB0[x], in_pixel} (top, middle, bottom).
- Interior rule: win_valid asserts the cycle after acceptance iff x >= 2 and y >= 2. Latency is one clock.
- Window contents when valid:
  - pixel0 = P(x-2,y-2), pixel1 = P(x-1,y-2), pixel2 = P(x,y-2)
  - pixel3 = P(x-2,y-1), pixel4 = P(x-1,y-1), pixel5 = P(x,y-1)
  - pixel6 = P(x-2,y), pixel7 = P(x-1,y), pixel8 = P(x,y)
- Window column continuity: the window never straddles lines. At x = 0 and x = 1 the window shifts but win_valid stays 0.
- win_last = win_valid AND x = IMG_WIDTH-1 AND y = IMG_HEIGHT-1.
- Window count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) pulses per complete frame.
- Pixel outputs hold their last value while win_valid = 0.
- Mid-frame in_sof: the partial frame is abandoned and no flush occurs. Stale line-buffer data is never emitted, because the rows it would feed (y < 2) are non-interior.
- Reset mid-frame: outputs clear immediately (asynchronous). The first pixel after release is (0,0).
- Arithmetic: x width = clog2(IMG_WIDTH), y width = clog2(IMG_HEIGHT), both unsigned.

Decomposition:
- Package sobel_pkg holds: PIX_W; default IMG_WIDTH/IMG_HEIGHT; X_W/Y_W constants derived with clog2.
- Sub-module sobel_line_buf:
  - depth IMG_WIDTH, width PIX_W;
  - one write and one read per cycle at the same address, read-before-write;
  - inferable as M10K;
  - instantiated twice, or once at width 2*PIX_W.
- Read timing must reproduce the timing above. The address is prefetched from next-x when the RAM read is synchronous.

Test Plan:
- Ramp frame, IMG_WIDTH=8, IMG_HEIGHT=4, P(x,y) = y*16+x, continuous valid:
  - 12 win_valid pulses.
  - First pulse after (2,2) with pixel0..8 = 00 01 02 10 11 12 20 21 22.
  - Last pulse has win_last = 1, pixel4 = 26, pixel8 = 37.
- Same frame with in_valid toggling 1,0,1,0 -> identical 12 windows in the same order; win_valid never high on a gap cycle.
- in_sof reasserted after 10 pixels of the ramp frame -> no win_valid until new-frame pixel (2,2); first window = 00..22 as in the first test.
- rst_n low for 3 cycles while at pixel (5,2) -> win_valid, win_last and pixel0..8 read 0 during reset. After release, 32 ramp pixels give exactly 12 windows again.
- 33 pixels, no in_sof, 8x4 frame -> pixel 33 is taken as (0,0); next windows appear only from new-frame (2,2) onward; win_last exactly once per 32 pixels.
- Chained with sobel_conv:
  - 8x4 frame all 0x80 -> op_val = 00 on every valid window.
  - Frame with columns x >= 4 = FF and others 00 -> op_val = FF on windows centred at x = 3, 4; 00 at x = 1, 2, 5, 6.

Source files
------------

// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared constants for the Sobel 3x3 window generator: pixel width, default
// frame geometry and the counter widths derived from it.
// -----------------------------------------------------------------------------
package sobel_pkg;

  localparam int PIX_W          = 8;
  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int X_W_DEF = cnt_width(IMG_WIDTH_DEF);
  localparam int Y_W_DEF = cnt_width(IMG_HEIGHT_DEF);

endpackage

// File: rtl/sobel_window_gen_if.sv
// -----------------------------------------------------------------------------
// sobel_window_gen_if
// Pixel-in / window-out bundle of the Sobel window generator.
//   in_valid, in_sof, in_pixel : raster pixel stream (no backpressure)
//   win_valid, win_last        : window strobe and end-of-frame marker
//   pixel0..pixel8             : 3x3 window, row-major, pixel4 = centre
// Modports:
//   master : stream source / window consumer
//   slave  : the window generator itself
// -----------------------------------------------------------------------------
interface sobel_window_gen_if;
  import sobel_pkg::*;

  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic             win_valid;
  logic             win_last;
  logic [PIX_W-1:0] pixel0;
  logic [PIX_W-1:0] pixel1;
  logic [PIX_W-1:0] pixel2;
  logic [PIX_W-1:0] pixel3;
  logic [PIX_W-1:0] pixel4;
  logic [PIX_W-1:0] pixel5;
  logic [PIX_W-1:0] pixel6;
  logic [PIX_W-1:0] pixel7;
  logic [PIX_W-1:0] pixel8;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  win_valid, win_last,
    input  pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output win_valid, win_last,
    output pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8
  );

endinterface

// File: rtl/sobel_line_buf.sv
// -----------------------------------------------------------------------------
// sobel_line_buf
// Simple dual-port line memory, DEPTH x WIDTH, one write and one registered
// read per cycle. A read of the address being written returns the old word.
// No reset on the array or the read register so it maps onto block RAM.
// Ports:
//   clk      : clock
//   we       : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address (data appears after the next rising edge)
//   rd_data  : registered read data
// -----------------------------------------------------------------------------
module sobel_line_buf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sobel_window_gen.sv
// -----------------------------------------------------------------------------
// sobel_window_gen
// Streaming 3x3 window generator feeding the combinational Sobel operator.
// Tracks the raster position of each accepted pixel, keeps the two previous
// lines in one double-width line memory and emits a window one clock after
// every pixel whose window lies fully inside the frame.
// Ports:
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : sobel_window_gen_if.slave (pixel stream in, window out)
// Parameters:
//   IMG_WIDTH  : active pixels per line (>= 3)
//   IMG_HEIGHT : active lines per frame (>= 3)
// -----------------------------------------------------------------------------
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  sobel_window_gen_if.slave bus
);

  localparam int X_W = cnt_width(IMG_WIDTH);
  localparam int Y_W = cnt_width(IMG_HEIGHT);

  logic [X_W-1:0] x_cnt, x_pos, x_nxt, rd_addr;
  logic [Y_W-1:0] y_cnt, y_pos, y_nxt;
  logic           accept, x_end, y_end, interior;

  // Column arrays: index 2 = top row, 1 = middle, 0 = bottom.
  logic [2:0][PIX_W-1:0] col_old, col_mid, col_new;
  logic [8:0][PIX_W-1:0] win_q, win_nxt;
  logic                  win_valid_q, win_last_q;

  logic [2*PIX_W-1:0] lb_rd;
  logic [PIX_W-1:0]   lb0_rd, lb1_rd;

  assign accept = bus.in_valid;
  assign lb1_rd = lb_rd[2*PIX_W-1:PIX_W];
  assign lb0_rd = lb_rd[PIX_W-1:0];

  always_comb begin
    x_pos = x_cnt;
    y_pos = y_cnt;
    if (bus.in_sof) begin
      x_pos = '0;
      y_pos = '0;
    end
    x_end    = (x_pos == X_W'(IMG_WIDTH - 1));
    y_end    = (y_pos == Y_W'(IMG_HEIGHT - 1));
    interior = (x_pos >= X_W'(2)) && (y_pos >= Y_W'(2));

    x_nxt = x_pos + X_W'(1);
    y_nxt = y_pos;
    if (x_end) begin
      x_nxt = '0;
      y_nxt = y_end ? '0 : y_pos + Y_W'(1);
    end

    // The line memory read is registered, so it is aimed at the column the
    // next accepted pixel will occupy. The in_sof override cannot be
    // anticipated; it only ever lands on row 0, whose line-memory data is
    // never part of an emitted window.
    rd_addr = accept ? x_nxt : x_cnt;
  end

  // One word per column: {row y-2, row y-1}. Writing {row y-1, new pixel}
  // ages both lines in a single access.
  sobel_line_buf #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (2 * PIX_W),
    .AW    (X_W)
  ) u_line_buf (
    .clk     (clk),
    .we      (accept),
    .wr_addr (x_pos),
    .wr_data ({lb0_rd, bus.in_pixel}),
    .rd_addr (rd_addr),
    .rd_data (lb_rd)
  );

  always_comb begin
    col_new    = {lb1_rd, lb0_rd, bus.in_pixel};
    win_nxt    = '0;
    win_nxt[0] = col_old[2];
    win_nxt[1] = col_mid[2];
    win_nxt[2] = col_new[2];
    win_nxt[3] = col_old[1];
    win_nxt[4] = col_mid[1];
    win_nxt[5] = col_new[1];
    win_nxt[6] = col_old[0];
    win_nxt[7] = col_mid[0];
    win_nxt[8] = col_new[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      col_old     <= '0;
      col_mid     <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      win_valid_q <= accept && interior;
      win_last_q  <= accept && interior && x_end && y_end;
      if (accept) begin
        x_cnt   <= x_nxt;
        y_cnt   <= y_nxt;
        col_old <= col_mid;
        col_mid <= col_new;
        // Output window only updates on a valid window so it holds otherwise.
        if (interior) win_q <= win_nxt;
      end
    end
  end

  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;
  assign bus.pixel0    = win_q[0];
  assign bus.pixel1    = win_q[1];
  assign bus.pixel2    = win_q[2];
  assign bus.pixel3    = win_q[3];
  assign bus.pixel4    = win_q[4];
  assign bus.pixel5    = win_q[5];
  assign bus.pixel6    = win_q[6];
  assign bus.pixel7    = win_q[7];
  assign bus.pixel8    = win_q[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_gen
// Self-checking bench for sobel_window_gen on an 8x4 frame. A reference model
// stores every accepted pixel in a frame image at its raster position and
// cuts the expected 3x3 window straight out of that image.
// -----------------------------------------------------------------------------
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int W = 8;
  localparam int H = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sobel_window_gen_if bus ();

  sobel_window_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          mx = 0;
  int          my = 0;
  logic [7:0]  img [H][W];
  logic [71:0] exp_win = '0;
  int          win_cnt = 0;
  int          last_cnt = 0;

  logic [71:0] obs_win;
  assign obs_win = {bus.pixel0, bus.pixel1, bus.pixel2,
                    bus.pixel3, bus.pixel4, bus.pixel5,
                    bus.pixel6, bus.pixel7, bus.pixel8};

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check 1 ns after the rising edge.
  task automatic step(input logic v, input logic s, input logic [7:0] p);
    int   px, py;
    logic ev, el;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_pixel = p;
    ev = 1'b0;
    el = 1'b0;
    if (v) begin
      px = s ? 0 : mx;
      py = s ? 0 : my;
      img[py][px] = p;
      if (px >= 2 && py >= 2) begin
        ev = 1'b1;
        el = (px == W - 1) && (py == H - 1);
        exp_win = {img[py-2][px-2], img[py-2][px-1], img[py-2][px],
                   img[py-1][px-2], img[py-1][px-1], img[py-1][px],
                   img[py][px-2],   img[py][px-1],   img[py][px]};
      end
      mx = px + 1;
      my = py;
      if (mx == W) begin
        mx = 0;
        my = (py + 1 == H) ? 0 : py + 1;
      end
    end
    @(posedge clk);
    #1;
    chk("win_valid", 72'(bus.win_valid), 72'(ev));
    chk("win_last", 72'(bus.win_last), 72'(el));
    chk("window", obs_win, exp_win);
    if (bus.win_valid === 1'b1) win_cnt++;
    if (bus.win_last === 1'b1) last_cnt++;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic ramp_pixels(input int n, input logic use_sof, input logic gaps);
    for (int i = 0; i < n; i++) begin
      int x, y;
      x = i % W;
      y = (i / W) % H;
      step(1'b1, use_sof && (i == 0), 8'(y * 16 + x));
      if (x == 2 && y == 2)
        chk("first_window", obs_win, 72'h00_01_02_10_11_12_20_21_22);
      if (x == W - 1 && y == H - 1) begin
        chk("last_flag", 72'(bus.win_last), 72'd1);
        chk("last_pixel4", 72'(bus.pixel4), 72'h26);
        chk("last_pixel8", 72'(bus.pixel8), 72'h37);
      end
      if (gaps) step(1'b0, 1'b0, 8'($urandom));
    end
  endtask

  task automatic check_counts(input string tag, input int exp_w, input int exp_l);
    chk({tag, "_windows"}, 72'(win_cnt), 72'(exp_w));
    chk({tag, "_lasts"}, 72'(last_cnt), 72'(exp_l));
    win_cnt  = 0;
    last_cnt = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    #1;
    chk("rst_valid", 72'(bus.win_valid), 72'd0);
    chk("rst_last", 72'(bus.win_last), 72'd0);
    chk("rst_window", obs_win, 72'd0);
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_hold_valid", 72'(bus.win_valid), 72'd0);
    chk("rst_hold_window", obs_win, 72'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    mx      = 0;
    my      = 0;
    exp_win = '0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pixel = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = '0;

    do_reset(3);

    // Continuous ramp frame
    ramp_pixels(W * H, 1'b1, 1'b0);
    check_counts("ramp", 12, 1);

    // Same frame with a gap after every pixel
    ramp_pixels(W * H, 1'b1, 1'b1);
    check_counts("gaps", 12, 1);

    // in_sof restarts the frame after 10 pixels
    ramp_pixels(10, 1'b1, 1'b0);
    ramp_pixels(W * H, 1'b1, 1'b0);
    check_counts("mid_sof", 12, 1);

    // Reset while the next pixel would be (5,2); restart without in_sof
    ramp_pixels(2 * W + 5, 1'b1, 1'b0);
    win_cnt  = 0;
    last_cnt = 0;
    do_reset(3);
    ramp_pixels(W * H, 1'b0, 1'b0);
    check_counts("after_reset", 12, 1);

    // Two back-to-back frames with no in_sof: pixel 33 is the new (0,0)
    ramp_pixels(W * H, 1'b0, 1'b0);
    ramp_pixels(W * H, 1'b0, 1'b0);
    check_counts("auto_wrap", 24, 2);

    // Random pixels, random valid gaps and occasional in_sof
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      s = (i == 0) || ($urandom_range(0, 59) == 0);
      step(v, s, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
